// File: rtl/dice_round_ctrl_pkg.sv
// Shared definitions for the dice round sequencer: FSM state encoding,
// LFSR seed/step, score ceiling and BCD split helpers.
package dice_round_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROLL  = 2'd1,
    ST_SCORE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [2:0]  LFSR_SEED  = 3'b100;
  localparam int unsigned MAX_POINTS = 99;

  // Maximal-length 3-bit LFSR: never reaches 0 from a non-zero seed.
  function automatic logic [2:0] lfsr_next(input logic [2:0] v);
    return {v[1:0], v[0] ^ v[2]};
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] p);
    return 4'(p / 7'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] p);
    return 4'(p % 7'd10);
  endfunction

endpackage

// File: rtl/dice_round_ctrl_btn_event.sv
// Tick-gated button sampler with rising-edge detect.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   tick  - one-cycle sample strobe
//   raw   - raw button level
//   evt   - one-cycle event on a tick where raw=1 and the previous sample was 0
module dice_round_ctrl_btn_event (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic evt
);

  logic sample_q, sample_d;

  always_comb begin
    sample_d = sample_q;
    if (tick) sample_d = raw;
  end

  always_ff @(posedge clk) begin
    if (reset) sample_q <= 1'b0;
    else       sample_q <= sample_d;
  end

  // A held button leaves sample_q high, so only the first tick fires.
  assign evt = tick & raw & ~sample_q;

endmodule

// File: rtl/dice_round_ctrl.sv
// Dice guessing game round sequencer. Owns the LFSR die, the 1..6 guess,
// the 0..99 score and its BCD split; turns raw buttons into tick-rate events
// and runs each round through IDLE -> ROLL -> SCORE -> IDLE/OVER.
// Ports:
//   rclock, reset                  - clock, synchronous active-high reset
//   btn_roll, btn_guess, btn_clear - raw button levels
//   guess      - current guess 1..6
//   die        - current LFSR value 1..7
//   point      - score 0..99, point_tens/point_ones its BCD digits
//   state      - IDLE=0, ROLL=1, SCORE=2, OVER=3
//   win        - last scored round was a hit
//   game_over  - high iff state is OVER
module dice_round_ctrl
  import dice_round_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 16777216,
  parameter int unsigned ROLL_TICKS   = 8,
  parameter int unsigned START_POINTS = 10,
  parameter int unsigned WIN_BONUS    = 6,
  parameter int unsigned LOSE_PENALTY = 1
) (
  input  logic       rclock,
  input  logic       reset,
  input  logic       btn_roll,
  input  logic       btn_guess,
  input  logic       btn_clear,
  output logic [2:0] guess,
  output logic [2:0] die,
  output logic [6:0] point,
  output logic [3:0] point_tens,
  output logic [3:0] point_ones,
  output logic [1:0] state,
  output logic       win,
  output logic       game_over
);

  localparam int unsigned PRE_W  = $clog2(TICK_DIV);
  localparam int unsigned SPIN_W = $clog2(ROLL_TICKS + 1);
  localparam logic [6:0]  START_P = 7'(START_POINTS);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick;
  logic              roll_evt, guess_evt, clear_evt;
  state_t            state_q, state_d;
  logic [2:0]        guess_q, guess_d;
  logic [2:0]        die_q, die_d;
  logic [6:0]        point_q, point_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              win_q, win_d;
  logic              over_q, over_d;
  logic [SPIN_W-1:0] spin_q, spin_d;
  logic [31:0]       point_up;

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  dice_round_ctrl_btn_event u_roll (
    .clk(rclock), .reset(reset), .tick(tick), .raw(btn_roll), .evt(roll_evt)
  );
  dice_round_ctrl_btn_event u_guess (
    .clk(rclock), .reset(reset), .tick(tick), .raw(btn_guess), .evt(guess_evt)
  );
  dice_round_ctrl_btn_event u_clear (
    .clk(rclock), .reset(reset), .tick(tick), .raw(btn_clear), .evt(clear_evt)
  );

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    die_d    = die_q;
    point_d  = point_q;
    win_d    = win_q;
    spin_d   = spin_q;
    point_up = 32'(point_q) + WIN_BONUS;

    if (clear_evt) begin
      // Clear aborts any spin but deliberately leaves the LFSR untouched.
      guess_d = 3'd1;
      point_d = START_P;
      win_d   = 1'b0;
      spin_d  = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (roll_evt) begin
            spin_d  = SPIN_W'(ROLL_TICKS);
            win_d   = 1'b0;
            state_d = ST_ROLL;
          end else if (guess_evt) begin
            guess_d = (guess_q == 3'd6) ? 3'd1 : guess_q + 3'd1;
          end
        end
        ST_ROLL: begin
          if (spin_q == '0) begin
            // 7 is not a die face: keep spinning one tick at a time.
            if (die_q != 3'd7)  state_d = ST_SCORE;
            else if (tick)      die_d   = lfsr_next(die_q);
          end else if (tick) begin
            die_d  = lfsr_next(die_q);
            spin_d = spin_q - 1'b1;
          end
        end
        ST_SCORE: begin
          if (die_q == guess_q) begin
            point_d = (point_up > MAX_POINTS) ? 7'(MAX_POINTS) : 7'(point_up);
            win_d   = 1'b1;
          end else if (32'(point_q) < LOSE_PENALTY) begin
            point_d = '0;
          end else begin
            point_d = 7'(32'(point_q) - LOSE_PENALTY);
          end
          state_d = (point_d == '0) ? ST_OVER : ST_IDLE;
        end
        ST_OVER: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Digits and game_over derive from next-state values so they update
    // in the same cycle as point/state.
    tens_d = bcd_tens(point_d);
    ones_d = bcd_ones(point_d);
    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge rclock) begin
    if (reset) begin
      pre_q   <= '0;
      state_q <= ST_IDLE;
      guess_q <= 3'd1;
      die_q   <= LFSR_SEED;
      point_q <= START_P;
      tens_q  <= bcd_tens(START_P);
      ones_q  <= bcd_ones(START_P);
      win_q   <= 1'b0;
      over_q  <= 1'b0;
      spin_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      guess_q <= guess_d;
      die_q   <= die_d;
      point_q <= point_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      win_q   <= win_d;
      over_q  <= over_d;
      spin_q  <= spin_d;
    end
  end

  assign guess      = guess_q;
  assign die        = die_q;
  assign point      = point_q;
  assign point_tens = tens_q;
  assign point_ones = ones_q;
  assign state      = state_q;
  assign win        = win_q;
  assign game_over  = over_q;

endmodule
